clk_tick_stepper: RTL and testbench
===================================

// Module: clk_tick_stepper
// PURPOSE
//  Sits directly downstream of the 2^n clock divider. Samples the divided clock
//  as data in the fast clockin domain and turns each rising edge into a
//  one-cycle tick. A run/step FSM gates those ticks into a single-cycle
//  cpu_en strobe, giving the MCU free-run or single-step execution.
//  Everything stays on one clock, so there are no derived clocks in the fabric.
// PARAMETERS
//  SYNC_STAGES  2   flops in each synchronizer (div_clk, run, step); legal range >=2
//  DB_N         8   consecutive equal step samples required to change debounced level
//  DB_W         4   width of debounce counter; must satisfy 2^DB_W > DB_N
//  CNT_W        16  width of en_count
// PORTS
//  clockin    in   1      system clock; all logic on posedge
//  reset_n    in   1      synchronous, active-low reset
//  div_clk    in   1      divider output, treated as asynchronous data
//  run        in   1      raw switch level; 1 = free-run
//  step       in   1      raw push-button, bouncy
//  tick       out  1      one-cycle pulse per synchronized rising edge of div_clk
//  cpu_en     out  1      one-cycle enable strobe to the MCU
//  state      out  2      FSM state: 00 IDLE, 01 RUN, 10 ARMED
//  en_count   out  CNT_W  number of cpu_en pulses issued, modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset_n=0 at a clockin edge):
//  - All sync flops, prev, debounce counter and level, tick, cpu_en and en_count go to 0.
//  - state goes to IDLE. Reset applied mid-step or mid-run discards pending activity.
//  Sync and edge detection:
//  - div_clk passes through SYNC_STAGES flops; ds = last stage; prev <= ds.
//  - tick is registered: tick <= ds & ~prev.
//  - Latency: tick is high in clock cycle SYNC_STAGES+1 counted from the first
//    clockin edge that samples div_clk=1. tick is never high in two consecutive cycles.
//  - div_clk high and low phases must each last >= SYNC_STAGES+1 clockin cycles.
//    A faster div_clk, including div_clk==clockin, is unsupported and tick is
//    unspecified, but it still never holds high for two consecutive cycles.
//  - run passes through its own SYNC_STAGES synchronizer, giving rs.
//  Step debounce:
//  - step passes through its own SYNC_STAGES synchronizer, giving ss.
//  - When ss != db_level, the counter increments; otherwise the counter clears to 0.
//  - When the counter reaches DB_N-1 with ss != db_level: db_level <= ss, counter <= 0.
//  - step_pulse (internal) is one cycle high on a db_level 0->1 transition.
//  FSM, registered, evaluated every clockin cycle (tick below means the registered tick value):
//  - IDLE:  rs=1 -> RUN; else if step_pulse -> ARMED. Here rs has priority over step_pulse.
//  - RUN:   cpu_en <= tick; rs=0 -> IDLE. step_pulse is ignored.
//           If tick and rs=0 occur in the same cycle, that tick still produces cpu_en.
//  - ARMED: tick -> cpu_en <= 1, go to IDLE. rs=1 -> RUN; the pending step is
//           absorbed and that tick follows RUN rules. Further step_pulses are ignored (no queue).
//  - cpu_en is 0 in every other case; it is never high for two consecutive cycles.
//  - en_count increments by 1 in the cycle after each cpu_en=1 and wraps from
//    2^CNT_W-1 to 0.
//  - state encoding 11 is unreachable; if entered, the FSM goes to IDLE next cycle.
// TESTING
//  1 Reset: hold reset_n=0 for 3 cycles with div_clk toggling -> tick=0, cpu_en=0,
//    state=00, en_count=0 throughout reset.
//  2 Tick latency: div_clk with period 32 cycles, 50% duty, run=0 -> tick high exactly
//    1 cycle, 3 cycles after sampling div_clk=1 (SYNC_STAGES=2); cpu_en stays 0;
//    state stays 00.
//  3 Free-run: run=1 for 10 div_clk periods -> state=01; 10 cpu_en pulses, each
//    coincident with tick+1 cycle; en_count=10.
//  4 Single step: run=0; step bounces 5 times (2-cycle glitches) then holds high for
//    20 cycles -> exactly one ARMED entry; cpu_en once on the next tick; state back to 00;
//    en_count +1.
//  5 Step ignored while armed: a second clean step press before the tick arrives ->
//    still only one cpu_en.
//    Step in RUN -> no extra cpu_en.
//  6 Wrap and mid-run reset: CNT_W=4, run 17 ticks -> en_count=1; then assert reset_n=0
//    while in RUN -> next cycle state=00, en_count=0, cpu_en=0.

Source files
------------

// File: rtl/clk_tick_stepper.sv
// Turns the sampled divider clock into one-cycle ticks and gates them into a
// cpu_en strobe through a free-run / single-step FSM, all on clockin.
module clk_tick_stepper #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_N        = 8,
  parameter int DB_W        = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clockin,
  input  logic             reset_n,
  input  logic             div_clk,
  input  logic             run,
  input  logic             step,
  output logic             tick,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] en_count
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_ARMED = 2'b10;

  logic [2:0] raw;
  logic [2:0] synced;
  logic       ds;
  logic       rs;
  logic       ss;

  assign raw = {step, run, div_clk};

  // Independent synchronizer chain per asynchronous input: 0 div_clk, 1 run, 2 step.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;
      always_ff @(posedge clockin) begin
        if (!reset_n) begin
          chain_reg <= '0;
        end else begin
          chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw[gi]};
        end
      end
      assign synced[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  assign ds = synced[0];
  assign rs = synced[1];
  assign ss = synced[2];

  logic prev_reg;
  logic tick_reg;

  always_ff @(posedge clockin) begin
    if (!reset_n) begin
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      prev_reg <= ds;
      tick_reg <= ds & ~prev_reg;
    end
  end

  logic [DB_W-1:0] db_cnt_reg;
  logic            db_level_reg;
  logic            db_prev_reg;
  logic            step_pulse;

  // The level only flips after DB_N consecutive disagreeing samples.
  always_ff @(posedge clockin) begin
    if (!reset_n) begin
      db_cnt_reg   <= '0;
      db_level_reg <= 1'b0;
      db_prev_reg  <= 1'b0;
    end else begin
      db_prev_reg <= db_level_reg;
      if (ss != db_level_reg) begin
        if (db_cnt_reg == DB_W'(DB_N - 1)) begin
          db_level_reg <= ss;
          db_cnt_reg   <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
  end

  assign step_pulse = db_level_reg & ~db_prev_reg;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic             cpu_en_reg;
  logic             cpu_en_next;
  logic [CNT_W-1:0] en_count_reg;

  always_comb begin
    state_next  = state_reg;
    cpu_en_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (rs) begin
          state_next = ST_RUN;
        end else if (step_pulse) begin
          state_next = ST_ARMED;
        end
      end
      ST_RUN: begin
        cpu_en_next = tick_reg;
        if (!rs) begin
          state_next = ST_IDLE;
        end
      end
      ST_ARMED: begin
        // Whether the step completes or run takes over, this tick is issued once.
        cpu_en_next = tick_reg;
        if (rs) begin
          state_next = ST_RUN;
        end else if (tick_reg) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clockin) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cpu_en_reg   <= 1'b0;
      en_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cpu_en_reg <= cpu_en_next;
      if (cpu_en_reg) begin
        en_count_reg <= en_count_reg + 1'b1;
      end
    end
  end

  assign tick     = tick_reg;
  assign cpu_en   = cpu_en_reg;
  assign state    = state_reg;
  assign en_count = en_count_reg;

endmodule

// File: tb/tb_clk_tick_stepper.sv
// Scoreboard bench for clk_tick_stepper: expected tick/cpu_en cycles are queued
// when div_clk rises and matched against the cycles where the DUT pulses.
module tb_clk_tick_stepper;

  logic       clockin = 1'b0;
  logic       reset_n = 1'b0;
  logic       div_clk = 1'b0;
  logic       run     = 1'b0;
  logic       step    = 1'b0;
  logic       tick;
  logic       cpu_en;
  logic [1:0] state;
  logic [3:0] en_count;

  int cyc           = 0;
  int checks        = 0;
  int errors        = 0;
  int armed_entries = 0;
  logic [1:0] last_state = 2'b00;
  logic [3:0] exp_count  = 4'd0;

  int exp_tick_q[$];
  int exp_en_q[$];
  int obs_tick_q[$];
  int obs_en_q[$];

  clk_tick_stepper #(
    .SYNC_STAGES(2),
    .DB_N(8),
    .DB_W(4),
    .CNT_W(4)
  ) dut (
    .clockin(clockin),
    .reset_n(reset_n),
    .div_clk(div_clk),
    .run(run),
    .step(step),
    .tick(tick),
    .cpu_en(cpu_en),
    .state(state),
    .en_count(en_count)
  );

  always #5 clockin = ~clockin;

  always @(posedge clockin) cyc <= cyc + 1;

  always @(negedge clockin) begin
    if (tick === 1'b1) obs_tick_q.push_back(cyc);
    if (cpu_en === 1'b1) obs_en_q.push_back(cyc);
    if (state == 2'b10 && last_state != 2'b10) armed_entries <= armed_entries + 1;
    last_state <= state;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clockin);
    #1;
  endtask

  // A div_clk rise driven after edge P is first sampled at P+1, ticks at P+3, enables at P+4.
  task automatic run_div(input int periods, input bit en);
    for (int p = 0; p < periods; p++) begin
      div_clk = 1'b1;
      exp_tick_q.push_back(cyc + 3);
      if (en) begin
        exp_en_q.push_back(cyc + 4);
        exp_count = exp_count + 4'd1;
      end
      cycles(16);
      div_clk = 1'b0;
      cycles(16);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      div_clk = ~div_clk;
      cycles(1);
      checks++;
      if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
      checks++;
      if (cpu_en !== 1'b0) begin errors++; $display("FAIL reset_cpu_en: got %b want 0", cpu_en); end
      checks++;
      if (state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b want 00", state); end
      checks++;
      if (en_count !== 4'd0) begin errors++; $display("FAIL reset_en_count: got %0d want 0", en_count); end
      $display("reset cycle %0d: tick=%b cpu_en=%b state=%b en_count=%0d", i, tick, cpu_en, state, en_count);
    end
    div_clk = 1'b0;
    reset_n = 1'b1;
    cycles(4);
    checks++;
    if (obs_tick_q.size() != 0 || obs_en_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pulses: got %0d ticks %0d enables want 0", obs_tick_q.size(), obs_en_q.size());
      obs_tick_q.delete();
      obs_en_q.delete();
    end
  endtask

  task automatic test_tick_latency();
    int e, o;
    run = 1'b0;
    run_div(2, 1'b0);
    while (exp_tick_q.size() > 0) begin
      e = exp_tick_q.pop_front();
      o = (obs_tick_q.size() > 0) ? obs_tick_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL latency_tick: got cycle %0d want %0d", o, e); end
      else $display("latency tick at cycle %0d", o);
    end
    checks++;
    if (obs_tick_q.size() != 0) begin errors++; $display("FAIL latency_extra_tick: got %0d want 0", obs_tick_q.size()); obs_tick_q.delete(); end
    checks++;
    if (obs_en_q.size() != 0) begin errors++; $display("FAIL latency_cpu_en: got %0d pulses want 0", obs_en_q.size()); obs_en_q.delete(); end
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL latency_state: got %b want 00", state); end
  endtask

  task automatic test_free_run();
    int e, o;
    run = 1'b1;
    cycles(5);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL run_state: got %b want 01", state); end
    run_div(10, 1'b1);
    while (exp_tick_q.size() > 0) begin
      e = exp_tick_q.pop_front();
      o = (obs_tick_q.size() > 0) ? obs_tick_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL run_tick: got cycle %0d want %0d", o, e); end
    end
    while (exp_en_q.size() > 0) begin
      e = exp_en_q.pop_front();
      o = (obs_en_q.size() > 0) ? obs_en_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL run_cpu_en: got cycle %0d want %0d", o, e); end
      else $display("run cpu_en at cycle %0d", o);
    end
    checks++;
    if (obs_tick_q.size() + obs_en_q.size() != 0) begin
      errors++; $display("FAIL run_extra: got %0d extra pulses want 0", obs_tick_q.size() + obs_en_q.size());
      obs_tick_q.delete(); obs_en_q.delete();
    end
    checks++;
    if (en_count !== exp_count) begin errors++; $display("FAIL run_en_count: got %0d want %0d", en_count, exp_count); end
    run = 1'b0;
    cycles(5);
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL run_stop_state: got %b want 00", state); end
  endtask

  task automatic test_single_step();
    int e, o, base;
    base = armed_entries;
    for (int i = 0; i < 5; i++) begin
      step = 1'b1; cycles(2);
      step = 1'b0; cycles(2);
    end
    checks++;
    if (state !== 2'b00 || armed_entries != base) begin
      errors++; $display("FAIL step_bounce: got state %b entries %0d want 00 and %0d", state, armed_entries, base);
    end
    step = 1'b1;
    cycles(20);
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL step_armed: got %b want 10", state); end
    step = 1'b0;
    cycles(20);
    run_div(1, 1'b1);
    while (exp_tick_q.size() > 0) begin
      e = exp_tick_q.pop_front();
      o = (obs_tick_q.size() > 0) ? obs_tick_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL step_tick: got cycle %0d want %0d", o, e); end
    end
    while (exp_en_q.size() > 0) begin
      e = exp_en_q.pop_front();
      o = (obs_en_q.size() > 0) ? obs_en_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL step_cpu_en: got cycle %0d want %0d", o, e); end
      else $display("step cpu_en at cycle %0d", o);
    end
    checks++;
    if (obs_tick_q.size() + obs_en_q.size() != 0) begin
      errors++; $display("FAIL step_extra: got %0d extra pulses want 0", obs_tick_q.size() + obs_en_q.size());
      obs_tick_q.delete(); obs_en_q.delete();
    end
    checks++;
    if (armed_entries != base + 1) begin errors++; $display("FAIL step_entries: got %0d want %0d", armed_entries, base + 1); end
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL step_state: got %b want 00", state); end
    checks++;
    if (en_count !== exp_count) begin errors++; $display("FAIL step_en_count: got %0d want %0d", en_count, exp_count); end
  endtask

  task automatic test_step_ignored();
    int e, o, base;
    base = armed_entries;
    for (int i = 0; i < 2; i++) begin
      step = 1'b1; cycles(20);
      step = 1'b0; cycles(20);
    end
    checks++;
    if (state !== 2'b10 || armed_entries != base + 1) begin
      errors++; $display("FAIL armed_twice: got state %b entries %0d want 10 and %0d", state, armed_entries, base + 1);
    end
    run_div(1, 1'b1);
    run_div(1, 1'b0);
    run = 1'b1;
    cycles(5);
    step = 1'b1; cycles(20);
    step = 1'b0; cycles(20);
    checks++;
    if (state !== 2'b01 || armed_entries != base + 1) begin
      errors++; $display("FAIL run_step: got state %b entries %0d want 01 and %0d", state, armed_entries, base + 1);
    end
    run_div(2, 1'b1);
    run = 1'b0;
    cycles(5);
    run_div(1, 1'b0);
    while (exp_tick_q.size() > 0) begin
      e = exp_tick_q.pop_front();
      o = (obs_tick_q.size() > 0) ? obs_tick_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL ignore_tick: got cycle %0d want %0d", o, e); end
    end
    while (exp_en_q.size() > 0) begin
      e = exp_en_q.pop_front();
      o = (obs_en_q.size() > 0) ? obs_en_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL ignore_cpu_en: got cycle %0d want %0d", o, e); end
      else $display("ignore-test cpu_en at cycle %0d", o);
    end
    checks++;
    if (obs_tick_q.size() + obs_en_q.size() != 0) begin
      errors++; $display("FAIL ignore_extra: got %0d extra pulses want 0", obs_tick_q.size() + obs_en_q.size());
      obs_tick_q.delete(); obs_en_q.delete();
    end
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL ignore_state: got %b want 00", state); end
    checks++;
    if (en_count !== exp_count) begin errors++; $display("FAIL ignore_en_count: got %0d want %0d", en_count, exp_count); end
  endtask

  task automatic test_wrap_reset();
    int e, o;
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    exp_count = 4'd0;
    cycles(2);
    run = 1'b1;
    cycles(5);
    run_div(17, 1'b1);
    checks++;
    if (en_count !== exp_count) begin errors++; $display("FAIL wrap_en_count: got %0d want %0d", en_count, exp_count); end
    $display("wrap en_count=%0d after 17 enables", en_count);
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL wrap_state: got %b want 01", state); end
    // Reset lands while a tick is registered, so its cpu_en must be discarded.
    div_clk = 1'b1;
    exp_tick_q.push_back(cyc + 3);
    cycles(3);
    reset_n = 1'b0;
    cycles(1);
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL midreset_state: got %b want 00", state); end
    checks++;
    if (en_count !== 4'd0) begin errors++; $display("FAIL midreset_en_count: got %0d want 0", en_count); end
    checks++;
    if (cpu_en !== 1'b0) begin errors++; $display("FAIL midreset_cpu_en: got %b want 0", cpu_en); end
    div_clk = 1'b0;
    run = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(4);
    while (exp_tick_q.size() > 0) begin
      e = exp_tick_q.pop_front();
      o = (obs_tick_q.size() > 0) ? obs_tick_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_tick: got cycle %0d want %0d", o, e); end
    end
    while (exp_en_q.size() > 0) begin
      e = exp_en_q.pop_front();
      o = (obs_en_q.size() > 0) ? obs_en_q.pop_front() : -1;
      checks++;
      if (o !== e) begin errors++; $display("FAIL wrap_cpu_en: got cycle %0d want %0d", o, e); end
    end
    checks++;
    if (obs_tick_q.size() + obs_en_q.size() != 0) begin
      errors++; $display("FAIL wrap_extra: got %0d extra pulses want 0", obs_tick_q.size() + obs_en_q.size());
      obs_tick_q.delete(); obs_en_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_tick_latency();
    test_free_run();
    test_single_step();
    test_step_ignored();
    test_wrap_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
